// File: rtl/score_pkg.sv
// Shared score format, saturation limit and game FSM encoding for the score keeper slice.
package score_pkg;

  localparam int SCORE_W = 20;
  localparam int FRAC_W  = 6;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 20'h9C3FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned adder clamped to a caller-supplied ceiling; the sum carries one guard bit so it never wraps.
module sat_add #(
  parameter int DATA_W = 20,
  parameter int ADD_W  = 10
) (
  input  logic [DATA_W-1:0] a,
  input  logic [ADD_W-1:0]  b,
  input  logic [DATA_W-1:0] max,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W:0] full;

  function automatic logic [DATA_W-1:0] sat(input logic [DATA_W:0] x,
                                            input logic [DATA_W-1:0] m);
    sat = (x > {1'b0, m}) ? m : x[DATA_W-1:0];
  endfunction

  assign full = {1'b0, a} + (DATA_W+1)'(b);
  assign sum  = sat(full, max);

endmodule

// File: rtl/score_keeper.sv
// Game score tracker: accumulates saturating points in PLAY, latches the best score at game end
// and alternates the display between score and highest while the game is over.
module score_keeper
  import score_pkg::*;
#(
  parameter int HI_PERIOD = 512,
  parameter int ADD_W     = 10
) (
  input  logic               segclk,
  input  logic               rst,
  input  logic               start,
  input  logic               over,
  input  logic               add_valid,
  input  logic [ADD_W-1:0]   add_amt,
  output logic               add_ready,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] highest,
  output logic               hi,
  output logic               new_record
);

  localparam int CNT_W = $clog2(HI_PERIOD + 1);

  state_t             state;
  logic [CNT_W-1:0]   hi_cnt;
  logic [SCORE_W-1:0] sum;
  logic [SCORE_W-1:0] final_score;
  logic               accept;
  logic               go_play;

  sat_add #(
    .DATA_W (SCORE_W),
    .ADD_W  (ADD_W)
  ) u_sat_add (
    .a   (score),
    .b   (add_amt),
    .max (SCORE_MAX),
    .sum (sum)
  );

  // add_ready is a registered copy of "in PLAY", so it also qualifies the transfer
  assign accept      = add_valid && add_ready;
  assign final_score = accept ? sum : score;
  assign go_play     = start && ((state != PLAY) || over);

  always_ff @(posedge segclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      score      <= '0;
      highest    <= '0;
      hi         <= 1'b0;
      new_record <= 1'b0;
      add_ready  <= 1'b0;
      hi_cnt     <= '0;
    end else if (go_play) begin
      state      <= PLAY;
      score      <= '0;
      new_record <= 1'b0;
      hi         <= 1'b0;
      hi_cnt     <= '0;
      add_ready  <= 1'b1;
    end else begin
      case (state)
        PLAY: begin
          if (accept)
            score <= sum;
          if (over) begin
            state     <= OVER;
            add_ready <= 1'b0;
            hi        <= 1'b0;
            hi_cnt    <= '0;
            if (final_score > highest) begin
              highest    <= final_score;
              new_record <= 1'b1;
            end
          end
        end
        OVER: begin
          if (hi_cnt == CNT_W'(HI_PERIOD - 1)) begin
            hi_cnt <= '0;
            hi     <= ~hi;
          end else begin
            hi_cnt <= hi_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          add_ready <= 1'b0;
          hi        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scenario bench for score_keeper: expected scores queued as adds are driven, compared as they appear.
module tb_score_keeper;
  import score_pkg::*;

  localparam int HP   = 4;
  localparam int AW   = 10;
  localparam int MAXI = 639999;

  logic               segclk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               over = 1'b0;
  logic               add_valid = 1'b0;
  logic [AW-1:0]      add_amt = '0;
  logic               add_ready;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] highest;
  logic               hi;
  logic               new_record;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int model = 0;

  score_keeper #(.HI_PERIOD(HP), .ADD_W(AW)) dut (
    .segclk     (segclk),
    .rst        (rst),
    .start      (start),
    .over       (over),
    .add_valid  (add_valid),
    .add_amt    (add_amt),
    .add_ready  (add_ready),
    .score      (score),
    .highest    (highest),
    .hi         (hi),
    .new_record (new_record)
  );

  always #5 segclk = ~segclk;

  task automatic step();
    @(posedge segclk);
    #1;
  endtask

  // Drive one add for the next edge and queue the score the model expects afterwards.
  task automatic drive_add(input int amt);
    add_valid = 1'b1;
    add_amt   = AW'(amt);
    model     = (model + amt > MAXI) ? MAXI : model + amt;
    exp_q.push_back(model);
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({score, highest, hi, new_record, add_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: score=%0d highest=%0d hi=%b nr=%b rdy=%b, required all 0",
               score, highest, hi, new_record, add_ready);
    end
    rst = 1'b0;
    step();
    checks++;
    if (add_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: add_ready=%b, required 0", add_ready);
    end
    add_valid = 1'b1;
    add_amt   = AW'(64);
    step();
    add_valid = 1'b0;
    checks++;
    if (score !== '0) begin
      errors++;
      $display("FAIL idle_add_ignored: score=%0d, required 0", score);
    end
  endtask

  task automatic test_basic();
    int e;
    start = 1'b1;
    step();
    start = 1'b0;
    model = 0;
    checks++;
    if (add_ready !== 1'b1 || score !== '0 || hi !== 1'b0) begin
      errors++;
      $display("FAIL start_play: rdy=%b score=%0d hi=%b, required 1 0 0", add_ready, score, hi);
    end
    for (int i = 0; i < 3; i++) begin
      drive_add(64);
      step();
      add_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (score !== SCORE_W'(e)) begin
        errors++;
        $display("FAIL basic_add%0d: score=%0d, required %0d", i, score, e);
      end
    end
    checks++;
    if ((score >> FRAC_W) !== 20'd3 || add_ready !== 1'b1 || hi !== 1'b0) begin
      errors++;
      $display("FAIL basic_integer: int=%0d rdy=%b hi=%b, required 3 1 0",
               score >> FRAC_W, add_ready, hi);
    end
    drive_add(128);
    step();
    add_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (score !== SCORE_W'(e)) begin
      errors++;
      $display("FAIL basic_320: score=%0d, required %0d", score, e);
    end
  endtask

  task automatic test_over_with_add();
    int e;
    drive_add(64);
    over = 1'b1;
    step();
    over      = 1'b0;
    add_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (score !== SCORE_W'(e)) begin
      errors++;
      $display("FAIL over_add_score: score=%0d, required %0d", score, e);
    end
    checks++;
    if (highest !== 20'd384 || new_record !== 1'b1 || add_ready !== 1'b0 || hi !== 1'b0) begin
      errors++;
      $display("FAIL over_add_record: highest=%0d nr=%b rdy=%b hi=%b, required 384 1 0 0",
               highest, new_record, add_ready, hi);
    end
    add_valid = 1'b1;
    add_amt   = AW'(64);
    step();
    add_valid = 1'b0;
    checks++;
    if (score !== 20'd384) begin
      errors++;
      $display("FAIL over_add_ignored: score=%0d, required 384", score);
    end
  endtask

  task automatic test_equal_game();
    int e;
    int hi_exp[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    start = 1'b1;
    step();
    start = 1'b0;
    model = 0;
    checks++;
    if (score !== '0 || new_record !== 1'b0 || highest !== 20'd384) begin
      errors++;
      $display("FAIL regame_clear: score=%0d nr=%b highest=%0d, required 0 0 384",
               score, new_record, highest);
    end
    for (int i = 0; i < 6; i++) begin
      drive_add(64);
      step();
      add_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (score !== SCORE_W'(e)) begin
        errors++;
        $display("FAIL equal_add%0d: score=%0d, required %0d", i, score, e);
      end
    end
    over = 1'b1;
    step();
    over = 1'b0;
    checks++;
    if (highest !== 20'd384 || new_record !== 1'b0) begin
      errors++;
      $display("FAIL equal_no_record: highest=%0d nr=%b, required 384 0", highest, new_record);
    end
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      checks++;
      if (hi !== 1'(hi_exp[i])) begin
        errors++;
        $display("FAIL hi_seq%0d: hi=%b, required %0d", i, hi, hi_exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    start = 1'b1;
    step();
    start = 1'b0;
    model = 0;
    for (int i = 0; i < 2; i++) begin
      drive_add(200);
      step();
      add_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (score !== SCORE_W'(e)) begin
        errors++;
        $display("FAIL b2b_add%0d: score=%0d, required %0d", i, score, e);
      end
    end
    start = 1'b1;
    over  = 1'b1;
    step();
    start = 1'b0;
    over  = 1'b0;
    model = 0;
    checks++;
    if (score !== '0 || add_ready !== 1'b1 || highest !== 20'd384 || hi !== 1'b0) begin
      errors++;
      $display("FAIL restart: score=%0d rdy=%b highest=%0d hi=%b, required 0 1 384 0",
               score, add_ready, highest, hi);
    end
    drive_add(64);
    step();
    add_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (score !== SCORE_W'(e)) begin
      errors++;
      $display("FAIL restart_play: score=%0d, required %0d", score, e);
    end
  endtask

  task automatic test_saturate();
    int e;
    int amt;
    while (model < 639900) begin
      amt = (639900 - model > 1023) ? 1023 : 639900 - model;
      drive_add(amt);
      step();
      add_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (score !== SCORE_W'(e)) begin
        errors++;
        $display("FAIL climb: score=%0d, required %0d", score, e);
      end
    end
    checks++;
    if (score !== 20'd639900) begin
      errors++;
      $display("FAIL climb_end: score=%0d, required 639900", score);
    end
    for (int i = 0; i < 2; i++) begin
      drive_add(1023);
      step();
      add_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (score !== SCORE_W'(e) || score !== 20'd639999) begin
        errors++;
        $display("FAIL sat%0d: score=%0d, required %0d", i, score, e);
      end
    end
    over = 1'b1;
    step();
    over = 1'b0;
    checks++;
    if (highest !== 20'd639999 || new_record !== 1'b1) begin
      errors++;
      $display("FAIL sat_record: highest=%0d nr=%b, required 639999 1", highest, new_record);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    start = 1'b1;
    step();
    start = 1'b0;
    model = 0;
    drive_add(500);
    step();
    add_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (score !== SCORE_W'(e)) begin
      errors++;
      $display("FAIL mid_score: score=%0d, required %0d", score, e);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({score, highest, hi, new_record, add_ready} !== '0) begin
      errors++;
      $display("FAIL async_reset: score=%0d highest=%0d hi=%b nr=%b rdy=%b, required all 0",
               score, highest, hi, new_record, add_ready);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (add_ready !== 1'b0 || highest !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b highest=%0d, required 0 0", add_ready, highest);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_over_with_add();
    test_equal_game();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
